// File: rtl/event_report_scheduler.sv
// event_report_scheduler
// Collects rising-edge events from up to four detector channels and timestamps
// each one with a prescaled 16-bit tick counter. A round-robin arbiter then
// serialises the reports as byte packets over a valid/ready UART-style
// interface: header, timestamp high, timestamp low.
// Optional feature macro: REPORT_CHECKSUM_EN appends an XOR checksum byte,
// which makes each packet four bytes long.
module event_report_scheduler #(
  parameter int NCH      = 4,
  parameter int PRESCALE = 100
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] eventDetected,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic           busy
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [1:0]  LAST_RST  = 2'(NCH - 1);

`ifdef REPORT_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_TSH  = 3'd2,
    ST_TSL  = 3'd3,
    ST_CHK  = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_TSH  = 3'd2,
    ST_TSL  = 3'd3
  } state_t;
`endif

  // Header byte: fixed 101 marker, overflow flag, two zero bits, channel id.
  function automatic logic [7:0] hdr_byte(input logic ovf, input logic [1:0] ch);
    return {3'b101, ovf, 2'b00, ch};
  endfunction

`ifdef REPORT_CHECKSUM_EN
  // Packet checksum: XOR of the three preceding bytes.
  function automatic logic [7:0] xor_sum(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] c);
    return a ^ b ^ c;
  endfunction
`endif

  // Round-robin pick: search begins one past the last granted channel.
  // Returns {found, channel}.
  function automatic logic [2:0] rr_pick(input logic [NCH-1:0] pend,
                                         input logic [1:0]     last_g);
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'b00;
    for (int i = 1; i <= NCH; i++) begin
      idx = 2'((int'(last_g) + i) % NCH);
      if (!found && pend[idx]) begin
        found = 1'b1;
        win   = idx;
      end else begin
        found = found;
      end
    end
    return {found, win};
  endfunction

  // Timestamp generation
  logic [15:0] presc_q, presc_d;
  logic [15:0] ts_cnt_q, ts_cnt_d;

  // Edge detection
  logic [NCH-1:0] evt_hist_q, evt_hist_d;
  logic [NCH-1:0] det_s;

  // Per-channel pending state
  logic [NCH-1:0] pending_q, pending_d;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic [15:0]    ts_q [NCH];
  logic [15:0]    ts_d [NCH];

  // Arbitration and packet state
  state_t      state_q, state_d;
  logic [1:0]  last_q, last_d;
  logic [15:0] ts_sh_q, ts_sh_d;
  logic        ovf_sh_q, ovf_sh_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        busy_q, busy_d;

  logic [2:0]  pick_s;
  logic        grant_s;
  logic [1:0]  grant_idx_s;
  logic        xfer_s;

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;

  assign det_s       = eventDetected & ~evt_hist_q;
  assign pick_s      = rr_pick(pending_q, last_q);
  assign grant_s     = (state_q == ST_IDLE) && pick_s[2];
  assign grant_idx_s = pick_s[1:0];
  assign xfer_s      = tx_valid_q & tx_ready;

  // Prescaler divides the clock; the timestamp wraps naturally at 16 bits.
  always_comb begin
    presc_d  = presc_q;
    ts_cnt_d = ts_cnt_q;
    if (presc_q == PRESC_MAX) begin
      presc_d  = 16'h0000;
      ts_cnt_d = ts_cnt_q + 16'h0001;
    end else begin
      presc_d  = presc_q + 16'h0001;
    end
  end

  // Previous-edge history of the event lines.
  always_comb begin
    evt_hist_d = eventDetected;
  end

  // Pending/overflow/timestamp update. A grant and a new event on the same
  // channel at the same edge start a fresh report instead of flagging overflow.
  always_comb begin
    pending_d = pending_q;
    ovf_d     = ovf_q;
    ts_d      = ts_q;
    for (int c = 0; c < NCH; c++) begin
      if (grant_s && (int'(grant_idx_s) == c)) begin
        if (det_s[c]) begin
          pending_d[c] = 1'b1;
          ovf_d[c]     = 1'b0;
          ts_d[c]      = ts_cnt_q;
        end else begin
          pending_d[c] = 1'b0;
          ovf_d[c]     = 1'b0;
        end
      end else if (det_s[c]) begin
        if (pending_q[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          pending_d[c] = 1'b1;
          ts_d[c]      = ts_cnt_q;
        end
      end else begin
        pending_d[c] = pending_q[c];
      end
    end
  end

  // Packet FSM: next state, shadow capture and registered output bytes.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    ts_sh_d    = ts_sh_q;
    ovf_sh_d   = ovf_sh_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          state_d    = ST_HDR;
          last_d     = grant_idx_s;
          ts_sh_d    = ts_q[grant_idx_s];
          ovf_sh_d   = ovf_q[grant_idx_s];
          tx_valid_d = 1'b1;
          tx_data_d  = hdr_byte(ovf_q[grant_idx_s], grant_idx_s);
        end else begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end
      end
      ST_HDR: begin
        if (xfer_s) begin
          state_d   = ST_TSH;
          tx_data_d = ts_sh_q[15:8];
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_TSH: begin
        if (xfer_s) begin
          state_d   = ST_TSL;
          tx_data_d = ts_sh_q[7:0];
        end else begin
          state_d = ST_TSH;
        end
      end
      ST_TSL: begin
        if (xfer_s) begin
`ifdef REPORT_CHECKSUM_EN
          state_d   = ST_CHK;
          tx_data_d = xor_sum(hdr_byte(ovf_sh_q, last_q), ts_sh_q[15:8], ts_sh_q[7:0]);
`else
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
`endif
        end else begin
          state_d = ST_TSL;
        end
      end
`ifdef REPORT_CHECKSUM_EN
      ST_CHK: begin
        if (xfer_s) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          tx_data_d  = 8'h00;
        end else begin
          state_d = ST_CHK;
        end
      end
`endif
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
        tx_data_d  = 8'h00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Timestamp and prescaler registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q  <= 16'h0000;
      ts_cnt_q <= 16'h0000;
    end else begin
      presc_q  <= presc_d;
      ts_cnt_q <= ts_cnt_d;
    end
  end

  // Edge-detector history register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      evt_hist_q <= '0;
    end else begin
      evt_hist_q <= evt_hist_d;
    end
  end

  // Per-channel pending, overflow and captured timestamp registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      ovf_q     <= '0;
      for (int c = 0; c < NCH; c++) begin
        ts_q[c] <= 16'h0000;
      end
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      for (int c = 0; c < NCH; c++) begin
        ts_q[c] <= ts_d[c];
      end
    end
  end

  // FSM state, shadow and output registers; reset abandons any packet.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_RST;
      ts_sh_q    <= 16'h0000;
      ovf_sh_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ts_sh_q    <= ts_sh_d;
      ovf_sh_q   <= ovf_sh_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: doc/event_report_scheduler.md
EVENT_REPORT_SCHEDULER -- requirements
Module: event_report_scheduler

Interface
- REQ-001 SHALL have parameter NCH, default 4: number of event channels, legal range 1..4.
- REQ-002 SHALL have parameter PRESCALE, default 100: clocks per timestamp tick, legal range 1..65535.
- REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
- REQ-005 SHALL have port eventDetected  input  NCH  per-channel event lines from the detectors.
- REQ-006 SHALL have port tx_data  output  8  report byte offered to the UART transmitter.
- REQ-007 SHALL have port tx_valid  output  1  tx_data is valid.
- REQ-008 SHALL have port tx_ready  input  1  the transmitter accepts the byte.
- REQ-009 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
- REQ-010 SHALL keep a 16-bit timestamp counter: +1 every PRESCALE clocks, wraps 0xFFFF->0x0000.
- REQ-011 SHALL detect an event on channel c when eventDetected[c] is sampled 1 at an edge and was 0 at the previous edge; a level held high SHALL count as one event.
- REQ-012 SHALL, on a detected event with pending[c]=0, set pending[c] at that edge and capture the pre-increment timestamp value into ts[c].
- REQ-013 SHALL, on a detected event with pending[c]=1, set sticky ovf[c] and keep ts[c] unchanged.
- REQ-014 SHALL, if an event is detected on channel c at the same edge that c is granted, set pending[c] again and capture the new timestamp; ovf[c] SHALL NOT be set.
- REQ-015 SHALL use FSM states IDLE, HDR, TSH, TSL, CHK (CHK only per REQ-026).
- REQ-016 SHALL, in IDLE with any pending bit set, grant one channel at the next edge by round-robin: search starts at the channel after the last granted one; the last-granted pointer resets to NCH-1, so channel 0 wins first.
- REQ-017 SHALL, at grant, clear pending[g] and ovf[g], latch ts[g] and ovf[g] into a shadow register, and enter HDR.
- REQ-018 SHALL drive the header byte as {3'b101, ovf_shadow, 2'b00, g[1:0]}.
- REQ-019 SHALL drive the byte sequence HDR -> TSH (ts[15:8]) -> TSL (ts[7:0]) -> IDLE, or -> CHK -> IDLE when CHK is compiled in.
- REQ-020 SHALL assert tx_valid in HDR, TSH, TSL and CHK, and hold tx_data stable until the transfer completes.
- REQ-021 SHALL treat a transfer as complete only at an edge where tx_valid=1 and tx_ready=1, and advance state only on a completed transfer.
- REQ-022 SHALL, on the edge that completes the last byte, return to IDLE with tx_valid=0 for at least one cycle before a new header starts.
- REQ-023 SHALL give a latency of two edges from event detection (edge k) to tx_valid=1: grant at k+1, header valid after edge k+1.

Reset
- REQ-024 SHALL, while reset=0, immediately force: tx_valid=0, tx_data=0x00, busy=0, state=IDLE, pending=0, ovf=0, all ts[]=0, timestamp counter=0, prescaler=0, last-granted=NCH-1, edge-detector history=0.
- REQ-025 SHALL, on reset assertion mid-packet, abandon the packet; it SHALL NOT resume after reset is released.

Configuration
- REQ-026 SHALL compile in the CHK state only when REPORT_CHECKSUM_EN is defined; CHK sends the XOR of the header, TSH and TSL bytes, giving 4-byte packets. Without REPORT_CHECKSUM_EN, packets are 3 bytes, TSL returns directly to IDLE, and no checksum logic exists.

Verification
- REQ-027 SHALL cover: PRESCALE=1, tx_ready=1, pulse ch0 when the counter reads 0x0012 -> bytes 0xA0, 0x00, 0x12 (plus 0xB2 with REPORT_CHECKSUM_EN); tx_valid high two edges after detection.
- REQ-028 SHALL cover: ch1 and ch3 pulsed at the same edge right after reset -> ch1 packet then ch3 packet (header 0xA1 then 0xA3); next simultaneous ch0+ch1 -> ch3 last granted, so ch0 first.
- REQ-029 SHALL cover: ch2 pulsed three times while a ch0 packet is stalled with tx_ready=0 -> one ch2 packet, header 0xB2, timestamp of the first pulse.
- REQ-030 SHALL cover: tx_ready toggled 0/1 every cycle -> tx_data constant while tx_valid=1 and tx_ready=0; exactly 3 (or 4) transfers per packet.
- REQ-031 SHALL cover: reset pulsed low during TSH -> tx_valid=0 and busy=0 asynchronously; no bytes after release until a new event.
- REQ-032 SHALL cover: counter preset near wrap with PRESCALE=1, event at 0xFFFF -> bytes 0xFF, 0xFF; an event one tick later reports 0x00, 0x00.
